// File: rtl/hazard_scheduler.sv
// ============================================================================
// hazard_scheduler : in-order issue control with a 3-deep destination
//                    scoreboard, branch wait/flush and jump bubble handling.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scheduler #(
    parameter int BR_TIMEOUT = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        branch_resolved,
    input  logic        branch_taken,
    output logic        issue,
    output logic        pc_write,
    output logic        flush,
    output logic [4:0]  rd_fut_1,
    output logic [4:0]  rd_fut_2,
    output logic [4:0]  rd_fut_3,
    output logic [5:0]  op_fut_1,
    output logic [5:0]  op_fut_2,
    output logic [7:0]  stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [2:0] BR_LAST  = 3'(BR_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2,
        J_BUB   = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  br_cnt;

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        use_rs;
    logic        use_rt;
    logic        hazard;
    logic        unused_shamt;

    assign opcode       = instr[31:26];
    assign func         = instr[5:0];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign unused_shamt = ^instr[10:6];

    function automatic logic in_flight(input logic [4:0] r);
        return (r != 5'd0) && ((r == rd_fut_1) || (r == rd_fut_2) || (r == rd_fut_3));
    endfunction

    always_comb begin
        dest   = 5'd0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        if (opcode == OP_RTYPE) begin
            dest   = (func == FN_JR) ? 5'd0 : instr[15:11];
            use_rs = 1'b1;
            use_rt = 1'b1;
        end else if ((opcode[5:3] == 3'b001) || (opcode == OP_LW)) begin
            dest   = instr[20:16];
            use_rs = 1'b1;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_SW)) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
        end else if (opcode == OP_JAL) begin
            dest   = 5'd31;
        end
    end

    assign hazard   = (use_rs && in_flight(rs)) || (use_rt && in_flight(rt));
    // Gated by reset directly so the outputs drop the instant reset asserts.
    assign issue    = reset && (state == RUN) && !hazard;
    assign pc_write = issue;
    assign flush    = reset && (state == FLUSH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            br_cnt      <= 3'd0;
            rd_fut_1    <= 5'd0;
            rd_fut_2    <= 5'd0;
            rd_fut_3    <= 5'd0;
            op_fut_1    <= 6'd0;
            op_fut_2    <= 6'd0;
            stall_count <= 8'd0;
        end else begin
            rd_fut_3 <= rd_fut_2;
            rd_fut_2 <= rd_fut_1;
            rd_fut_1 <= issue ? dest : 5'd0;
            op_fut_2 <= op_fut_1;
            op_fut_1 <= issue ? opcode : 6'd0;

            if (!issue && (stall_count != 8'hFF)) begin
                stall_count <= stall_count + 8'd1;
            end

            case (state)
                RUN: begin
                    if (issue && ((opcode == OP_BEQ) || (opcode == OP_BNE))) begin
                        state  <= BR_WAIT;
                        br_cnt <= 3'd0;
                    end else if (issue && ((opcode == OP_J) || (opcode == OP_JAL))) begin
                        state  <= J_BUB;
                    end
                end
                BR_WAIT: begin
                    if (branch_resolved) begin
                        state <= branch_taken ? FLUSH : RUN;
                    end else if (br_cnt == BR_LAST) begin
                        state <= RUN;
                    end else begin
                        br_cnt <= br_cnt + 3'd1;
                    end
                end
                FLUSH:   state <= RUN;
                J_BUB:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
// ============================================================================
// tb_hazard_scheduler : directed vectors with a queued scoreboard and a
//                       negedge monitor for hazard_scheduler.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scheduler;

    localparam logic [31:0] ADD3 = 32'h00221820;
    localparam logic [31:0] ADD5 = 32'h00642820;
    localparam logic [31:0] NOP  = 32'h00000020;
    localparam logic [31:0] BEQ  = 32'h10220004;
    localparam logic [31:0] JAL  = 32'h0C000010;
    localparam logic [31:0] JR3  = 32'h00600008;

    typedef struct packed {
        logic       iss;
        logic       pcw;
        logic       fl;
        logic [4:0] rd1;
        logic [4:0] rd2;
        logic [4:0] rd3;
        logic [5:0] op1;
        logic [5:0] op2;
        logic [7:0] st;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        branch_resolved;
    logic        branch_taken;
    logic        issue;
    logic        pc_write;
    logic        flush;
    logic [4:0]  rd_fut_1;
    logic [4:0]  rd_fut_2;
    logic [4:0]  rd_fut_3;
    logic [5:0]  op_fut_1;
    logic [5:0]  op_fut_2;
    logic [7:0]  stall_count;

    exp_t exp_q[$];
    int   id_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   vec_id = 0;
    int   stall_m = 0;

    hazard_scheduler #(.BR_TIMEOUT(7)) dut (
        .clock           (clock),
        .reset           (reset),
        .instr           (instr),
        .branch_resolved (branch_resolved),
        .branch_taken    (branch_taken),
        .issue           (issue),
        .pc_write        (pc_write),
        .flush           (flush),
        .rd_fut_1        (rd_fut_1),
        .rd_fut_2        (rd_fut_2),
        .rd_fut_3        (rd_fut_3),
        .op_fut_1        (op_fut_1),
        .op_fut_2        (op_fut_2),
        .stall_count     (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle just after the edge and queue what the outputs must show
    // during that cycle; stall_count is the only field tracked by a model.
    task automatic step(input logic rst, input logic [31:0] ins,
                        input logic res, input logic tkn,
                        input logic e_iss, input logic e_fl,
                        input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3,
                        input logic [5:0] o1, input logic [5:0] o2);
        exp_t e;
        @(posedge clock);
        #1;
        reset           = rst;
        instr           = ins;
        branch_resolved = res;
        branch_taken    = tkn;
        if (!rst) stall_m = 0;
        e = '{iss: e_iss, pcw: e_iss, fl: e_fl, rd1: e1, rd2: e2, rd3: e3,
              op1: o1, op2: o2, st: 8'(stall_m)};
        exp_q.push_back(e);
        id_q.push_back(vec_id);
        vec_id++;
        if (rst && !e_iss && stall_m != 255) stall_m++;
    endtask

    task automatic branch_timeout();
        step(1, BEQ, 0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, NOP, 0, 0, 0, 0, 0, 0, 0, 6'h04, 6'h00);
        step(1, NOP, 0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h04);
        for (int k = 0; k < 5; k++)
            step(1, NOP, 0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00);
    endtask

    always @(negedge clock) begin
        exp_t e;
        exp_t a;
        int   id;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = '{iss: issue, pcw: pc_write, fl: flush, rd1: rd_fut_1, rd2: rd_fut_2,
                   rd3: rd_fut_3, op1: op_fut_1, op2: op_fut_2, st: stall_count};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL vec%0d: got iss=%b pcw=%b fl=%b rd=%0d/%0d/%0d op=%h/%h st=%0d, want iss=%b pcw=%b fl=%b rd=%0d/%0d/%0d op=%h/%h st=%0d",
                         id, a.iss, a.pcw, a.fl, a.rd1, a.rd2, a.rd3, a.op1, a.op2, a.st,
                         e.iss, e.pcw, e.fl, e.rd1, e.rd2, e.rd3, e.op1, e.op2, e.st);
            end
        end
    end

    initial begin
        reset           = 1'b0;
        instr           = 32'h0;
        branch_resolved = 1'b0;
        branch_taken    = 1'b0;

        // reset held: nothing issues even with a clean instruction offered
        step(0, ADD3, 0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        step(0, ADD3, 0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00);

        // RAW on $3: three stall cycles while $3 walks through the scoreboard
        step(1, ADD3, 0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, ADD5, 0, 0, 0, 0, 3, 0, 0, 6'h00, 6'h00);
        step(1, ADD5, 0, 0, 0, 0, 0, 3, 0, 6'h00, 6'h00);
        step(1, ADD5, 0, 0, 0, 0, 0, 0, 3, 6'h00, 6'h00);
        step(1, ADD5, 0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 5, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0, 5, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0, 0, 5, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);

        // beq resolved taken in the second wait cycle, then one flush cycle
        step(1, BEQ,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 0, 0, 0, 0, 0, 6'h04, 6'h00);
        step(1, NOP,  1, 1, 0, 0, 0, 0, 0, 6'h00, 6'h04);
        step(1, NOP,  0, 0, 0, 1, 0, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);

        // beq never resolved: seven wait cycles, then a late resolve is ignored
        branch_timeout();
        step(1, NOP,  1, 1, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);

        // jal writes $31 and costs one bubble
        step(1, JAL,  0, 0, 1, 0, 0,  0,  0,  6'h00, 6'h00);
        step(1, NOP,  0, 0, 0, 0, 31, 0,  0,  6'h03, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0,  31, 0,  6'h00, 6'h03);
        step(1, NOP,  0, 0, 1, 0, 0,  0,  31, 6'h00, 6'h00);

        // reset pulsed mid-BR_WAIT clears everything without waiting for an edge
        step(1, ADD3, 0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, BEQ,  0, 0, 1, 0, 3, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 0, 0, 0, 3, 0, 6'h04, 6'h00);
        step(0, ADD3, 0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, ADD3, 0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);

        // jr reads rs only and writes nothing
        step(1, NOP,  0, 0, 1, 0, 3, 0, 0, 6'h00, 6'h00);
        step(1, JR3,  0, 0, 0, 0, 0, 3, 0, 6'h00, 6'h00);
        step(1, JR3,  0, 0, 0, 0, 0, 0, 3, 6'h00, 6'h00);
        step(1, JR3,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);

        // beq resolved not taken: straight back to RUN, no flush
        step(1, BEQ,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  1, 0, 0, 0, 0, 0, 0, 6'h04, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h04);

        // drive stall_count well past 255 to see it saturate, then clear it
        for (int n = 0; n < 40; n++) branch_timeout();
        step(1, NOP,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
        step(0, NOP,  0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        step(1, NOP,  0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
